// File: rtl/sreg_sipo_rx_if.sv
// Serial-in / parallel-out receiver bus: serial stimulus in, completed words and status out.
interface sreg_sipo_rx_if #(
    parameter int WIDTH = 8
);
    logic             sin;
    logic             sin_en;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;

    modport master (
        output sin, sin_en, start,
        input  dout, dout_valid, busy, frame_err
    );

    modport slave (
        input  sin, sin_en, start,
        output dout, dout_valid, busy, frame_err
    );
endinterface

// File: rtl/sreg_sipo_rx.sv
// Frame-based serial receiver: MSB-first bits qualified by sin_en, framed by start,
// presented as a registered parallel word with a one-cycle valid pulse.
//
//   state | meaning
//   IDLE  | waiting for start with sin_en; no partial frame held
//   SHIFT | frame partially received; bit_cnt bits captured so far
module sreg_sipo_rx #(
    parameter int WIDTH = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    sreg_sipo_rx_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    assign shifted  = {sreg_q[WIDTH-2:0], bus.sin};
    assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            bit_cnt_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            bit_cnt_q    <= bit_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        bit_cnt_d    = bit_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sin_en && bus.start) begin
                    sreg_d    = shifted;
                    bit_cnt_d = CW'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sin_en && bus.start) begin
                    // Restart: the current bit becomes the first bit of the new frame.
                    frame_err_d = 1'b1;
                    sreg_d      = shifted;
                    bit_cnt_d   = CW'(1);
                end else if (bus.sin_en) begin
                    sreg_d = shifted;
                    if (last_bit) begin
                        dout_d       = shifted;
                        dout_valid_d = 1'b1;
                        bit_cnt_d    = '0;
                        state_d      = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.dout       = dout_q;
        bus.dout_valid = dout_valid_q;
        bus.frame_err  = frame_err_q;
        bus.busy       = (state_q == SHIFT);
    end
endmodule

// File: tb/tb_sreg_sipo_rx.sv
// Bench for sreg_sipo_rx: directed frames plus random traffic against a bit-queue model.
module tb_sreg_sipo_rx;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    sreg_sipo_rx_if #(.WIDTH(8)) bus ();

    sreg_sipo_rx #(.WIDTH(8)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        int         cyc;
        logic       busy;
        logic       valid;
        logic       err;
        logic [7:0] dout;
    } exp_t;

    exp_t       sb[$];
    logic       bits[$];
    logic       in_frame;
    logic [7:0] last_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: compares every cycle that has an expectation recorded for it.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("record_cycle", 8'(e.cyc == cyc), 8'd1);
            chk("busy",       8'(bus.busy),       8'(e.busy));
            chk("dout_valid", 8'(bus.dout_valid), 8'(e.valid));
            chk("frame_err",  8'(bus.frame_err),  8'(e.err));
            chk("dout",       bus.dout,           e.dout);
        end
    end

    // One clock of stimulus; the model works on whole-frame bit lists.
    task automatic step(input logic r, input logic s, input logic en, input logic st);
        exp_t       e;
        logic [7:0] w;
        @(negedge clk);
        rst_n      = r;
        bus.sin    = s;
        bus.sin_en = en;
        bus.start  = st;
        e.valid = 1'b0;
        e.err   = 1'b0;
        if (!r) begin
            bits.delete();
            in_frame  = 1'b0;
            last_word = 8'h00;
        end else if (en && st) begin
            if (in_frame) e.err = 1'b1;
            bits.delete();
            bits.push_back(s);
            in_frame = 1'b1;
        end else if (en && in_frame) begin
            bits.push_back(s);
            if (bits.size() == 8) begin
                w = 8'h00;
                foreach (bits[i]) w = {w[6:0], bits[i]};
                last_word = w;
                e.valid   = 1'b1;
                in_frame  = 1'b0;
                bits.delete();
            end
        end
        e.cyc  = cyc + 1;
        e.busy = in_frame;
        e.dout = last_word;
        sb.push_back(e);
    endtask

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Sends the first n bits of w MSB first; gaps[i] idle cycles follow bit i.
    task automatic send_bits(input logic [7:0] w, input int n, input logic [7:0][3:0] gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b1, w[7-i], 1'b1, 1'(i == 0));
            idle_noise(int'(gaps[i]));
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bits.delete();
        in_frame  = 1'b0;
        last_word = 8'h00;
        #1;
        chk("rst_dout",       bus.dout,             8'h00);
        chk("rst_dout_valid", 8'(bus.dout_valid),   8'h00);
        chk("rst_busy",       8'(bus.busy),         8'h00);
        chk("rst_frame_err",  8'(bus.frame_err),    8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0][3:0] nogap;
        logic [7:0][3:0] g;
        checks     = 0;
        errors     = 0;
        in_frame   = 1'b0;
        last_word  = 8'h00;
        nogap      = '0;
        rst_n      = 1'b0;
        bus.sin    = 1'b0;
        bus.sin_en = 1'b0;
        bus.start  = 1'b0;
        #1;
        chk("init_dout",  bus.dout,           8'h00);
        chk("init_busy",  8'(bus.busy),       8'h00);
        chk("init_valid", 8'(bus.dout_valid), 8'h00);
        chk("init_err",   8'(bus.frame_err),  8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        send_bits(8'h6D, 8, nogap);
        idle_noise(2);

        g    = '0;
        g[1] = 4'd3;
        g[4] = 4'd1;
        send_bits(8'h6D, 8, g);
        idle_noise(2);

        send_bits(8'hA5, 8, nogap);
        send_bits(8'h3C, 8, nogap);
        idle_noise(2);

        send_bits(8'hFF, 4, nogap);
        send_bits(8'h12, 8, nogap);
        idle_noise(2);

        send_bits(8'hC3, 5, nogap);
        async_reset();
        send_bits(8'hC3, 8, nogap);

        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 11) == 0));
        end
        for (int k = 0; k < 6; k++) send_bits(8'($urandom), 8, nogap);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sreg_sipo_rx.md
SREG_SIPO_RX -- requirements
Module: sreg_sipo_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of serial bits per frame and the parallel word width (WIDTH >= 2).
REQ-002 SHALL have port sys_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port sin, input, 1, serial data bit, MSB of frame first.
REQ-005 SHALL have port sin_en, input, 1, qualifier; sin is sampled only on edges where sin_en=1.
REQ-006 SHALL have port start, input, 1, frame marker; start=1 with sin_en=1 marks sin as bit WIDTH-1 (first bit) of a new frame.
REQ-007 SHALL have port dout, output, WIDTH, last completed parallel word, registered.
REQ-008 SHALL have port dout_valid, output, 1, one-cycle pulse; dout is new.
REQ-009 SHALL have port busy, output, 1, high while a frame is partially received.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse; a partial frame was aborted by a new start.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE, SHIFT; a shift register sreg[WIDTH-1:0]; a bit counter bit_cnt of width $clog2(WIDTH+1).
REQ-012 In IDLE, on an edge with start=1 and sin_en=1: sreg <= {sreg[WIDTH-2:0], sin}, bit_cnt <= 1, go to SHIFT.
REQ-013 In IDLE, start=1 with sin_en=0 SHALL be ignored; sin_en=1 with start=0 SHALL be ignored (no capture, no state change).
REQ-014 In SHIFT, on an edge with sin_en=1 and start=0: shift in sin (left shift, LSB entry), bit_cnt <= bit_cnt+1.
REQ-015 In SHIFT, edges with sin_en=0 SHALL hold sreg, bit_cnt and state unchanged (gaps of any length allowed).
REQ-016 When the shift at REQ-014 captures bit number WIDTH (bit_cnt was WIDTH-1): dout <= {sreg[WIDTH-2:0], sin}, dout_valid <= 1 for exactly the next cycle, bit_cnt <= 0, state <= IDLE.
REQ-017 Latency: dout/dout_valid visible immediately after the edge capturing the last bit; no extra pipeline stage.
REQ-018 Back-to-back: a start with sin_en=1 on the cycle right after completion SHALL be accepted as a new frame (REQ-012) with no dead cycle.
REQ-019 In SHIFT, start=1 with sin_en=1 SHALL discard the partial frame, pulse frame_err for one cycle, and restart per REQ-012 using the current sin as the new first bit; dout SHALL NOT change.
REQ-020 In SHIFT, start=1 with sin_en=0 SHALL be ignored.
REQ-021 dout SHALL hold its value between completions; dout_valid and frame_err SHALL be 0 on every cycle not specified above.
REQ-022 busy SHALL equal (state == SHIFT), registered-state decode, no combinational path from inputs.
REQ-023 No partial word SHALL ever appear on dout.

Reset
REQ-024 sys_rst_n=0 SHALL immediately (asynchronously) force: state=IDLE, sreg=0, bit_cnt=0, dout=0, dout_valid=0, busy=0, frame_err=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame with no dout_valid or frame_err pulse; after release, the block waits for a new start.
REQ-026 First capture after reset release SHALL occur on the first rising edge where sys_rst_n=1, start=1, sin_en=1.

Verification
REQ-027 Basic: release reset, then 8 consecutive edges sin_en=1, sin=0,1,1,0,1,1,0,1 (start=1 on first only) -> dout=8'h6D, dout_valid high exactly one cycle after 8th edge, busy high for cycles after edges 1..7.
REQ-028 Gaps: same 8'h6D frame with sin_en=0 inserted for 3 cycles after bit 2 and 1 cycle after bit 5 -> dout=8'h6D, single dout_valid pulse, busy held through gaps.
REQ-029 Back-to-back: frame 8'hA5 immediately followed by 8'h3C (start on cycle after last A5 bit) -> two dout_valid pulses 8 cycles apart, dout=8'hA5 then 8'h3C.
REQ-030 Restart: 4 bits of 8'hFF, then start with 8'h12 -> one frame_err pulse at restart edge, dout stays at prior value until 8'h12 completes, then single dout_valid with dout=8'h12.
REQ-031 Reset mid-frame: assert sys_rst_n=0 between clock edges after 5 bits -> all outputs 0 immediately without waiting for an edge, no dout_valid; after release, a full 8'hC3 frame yields dout=8'hC3.
REQ-032 Ignored inputs: start=1 with sin_en=0, and sin_en=1 with start=0 while IDLE -> busy stays 0, dout unchanged, no pulses.
